// File: rtl/lcd_text_ctrl.sv
// HD44780 write-only 8-bit character LCD controller: power-up init, then continuous
// timed refresh of a host-writable LCD_COLS x LCD_ROWS character buffer.
module lcd_text_ctrl #(
  parameter int unsigned LCD_COLS    = 16,
  parameter int unsigned LCD_ROWS    = 2,
  parameter int unsigned PWRUP_CYC   = 750000,
  parameter int unsigned EN_CYC      = 16,
  parameter int unsigned CMD_CYC     = 2000,
  parameter int unsigned CLR_CYC     = 82000,
  parameter int unsigned REFRESH_CYC = 500000,
  localparam int unsigned NCHAR      = LCD_COLS * LCD_ROWS,
  localparam int unsigned AW         = (NCHAR > 1) ? $clog2(NCHAR) : 1
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iWR_EN,
  input  logic [AW-1:0] iWR_ADDR,
  input  logic [7:0]    iWR_DATA,
  output logic          oREADY,
  output logic          oFRAME,
  output logic [7:0]    LCD_DATA,
  output logic          LCD_RW,
  output logic          LCD_EN,
  output logic          LCD_RS
);

  localparam int unsigned MAX_A = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int unsigned MAX_B = (REFRESH_CYC > CMD_CYC) ? REFRESH_CYC : CMD_CYC;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAXW  = (MAX_C > EN_CYC) ? MAX_C : EN_CYC;
  localparam int unsigned CW    = $clog2(MAXW + 1);
  localparam int unsigned CLW   = (LCD_COLS > 1) ? $clog2(LCD_COLS) : 1;

  localparam logic [CW-1:0]  PWR_LAST = CW'(PWRUP_CYC - 1);
  localparam logic [CW-1:0]  EN_LAST  = CW'(EN_CYC - 1);
  localparam logic [CW-1:0]  CMD_LAST = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0]  CLR_LAST = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0]  GAP_LAST = CW'(REFRESH_CYC);
  localparam logic [CLW-1:0] COL_LAST = CLW'(LCD_COLS - 1);
  localparam logic           ROW_LAST = (LCD_ROWS > 1);
  localparam logic [7:0]     FSET     = (LCD_ROWS > 1) ? 8'h38 : 8'h30;

  typedef enum logic [2:0] {S_PWR, S_INIT, S_ADDR, S_CHAR, S_GAP} state_t;
  typedef enum logic [1:0] {PH_T0, PH_EN, PH_WAIT, PH_IDLE} phase_t;

  state_t         state_q, state_d;
  phase_t         phase_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     step_q, step_d;
  logic           row_q, row_d;
  logic [CLW-1:0] col_q, col_d;
  logic           long_q;
  logic [7:0]     buf_q [NCHAR];

  logic [AW-1:0]  rd_idx_d;
  logic [7:0]     data_d;
  logic           rs_d;
  logic           launch_d;
  logic           ready_d;
  logic           frame_d;
  logic           advance_d;
  logic [CW-1:0]  wait_last_d;

  function automatic logic [7:0] init_cmd(input logic [1:0] s);
    case (s)
      2'd0:    return FSET;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  assign LCD_RW = 1'b0;

  // Reads and writes share an edge; the non-blocking update means a launch sees the old char.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      for (int unsigned i = 0; i < NCHAR; i++) buf_q[i] <= 8'h20;
    end else if (iWR_EN && (32'(iWR_ADDR) < NCHAR)) begin
      buf_q[iWR_ADDR] <= iWR_DATA;
    end
  end

  always_comb begin
    rd_idx_d = AW'((32'(row_q) * LCD_COLS) +
                   ((state_q == S_CHAR) ? (32'(col_q) + 32'd1) : 32'd0));
    wait_last_d = long_q ? CLR_LAST : CMD_LAST;
    advance_d = 1'b0;
    unique case (phase_q)
      PH_WAIT: advance_d = (cnt_q == wait_last_d);
      PH_IDLE: advance_d = (cnt_q == ((state_q == S_GAP) ? GAP_LAST : PWR_LAST));
      default: advance_d = 1'b0;
    endcase
  end

  // What happens when the current wait expires: next transfer to launch and FSM move.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    row_d    = row_q;
    col_d    = col_q;
    data_d   = LCD_DATA;
    rs_d     = LCD_RS;
    launch_d = 1'b0;
    ready_d  = oREADY;
    frame_d  = 1'b0;
    case (state_q)
      S_PWR: begin
        state_d  = S_INIT;
        step_d   = 2'd0;
        data_d   = init_cmd(2'd0);
        rs_d     = 1'b0;
        launch_d = 1'b1;
      end
      S_INIT: begin
        if (step_q != 2'd3) begin
          step_d   = 2'(step_q + 2'd1);
          data_d   = init_cmd(2'(step_q + 2'd1));
          rs_d     = 1'b0;
          launch_d = 1'b1;
        end else begin
          ready_d  = 1'b1;
          state_d  = S_ADDR;
          row_d    = 1'b0;
          data_d   = 8'h80;
          rs_d     = 1'b0;
          launch_d = 1'b1;
        end
      end
      S_ADDR: begin
        state_d  = S_CHAR;
        col_d    = '0;
        data_d   = buf_q[rd_idx_d];
        rs_d     = 1'b1;
        launch_d = 1'b1;
      end
      S_CHAR: begin
        if (col_q != COL_LAST) begin
          col_d    = CLW'(col_q + 1'b1);
          data_d   = buf_q[rd_idx_d];
          rs_d     = 1'b1;
          launch_d = 1'b1;
        end else if (row_q != ROW_LAST) begin
          state_d  = S_ADDR;
          row_d    = 1'b1;
          data_d   = 8'hC0;
          rs_d     = 1'b0;
          launch_d = 1'b1;
        end else begin
          state_d  = S_GAP;
          frame_d  = 1'b1;
        end
      end
      S_GAP: begin
        state_d  = S_ADDR;
        row_d    = 1'b0;
        data_d   = 8'h80;
        rs_d     = 1'b0;
        launch_d = 1'b1;
      end
      default: state_d = S_PWR;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_PWR;
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      step_q   <= '0;
      row_q    <= 1'b0;
      col_q    <= '0;
      long_q   <= 1'b0;
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= '0;
      oREADY   <= 1'b0;
      oFRAME   <= 1'b0;
    end else begin
      oFRAME <= 1'b0;
      if (advance_d) begin
        state_q <= state_d;
        step_q  <= step_d;
        row_q   <= row_d;
        col_q   <= col_d;
        oREADY  <= ready_d;
        oFRAME  <= frame_d;
        cnt_q   <= '0;
        if (launch_d) begin
          LCD_DATA <= data_d;
          LCD_RS   <= rs_d;
          long_q   <= !rs_d && (data_d == 8'h01);
          phase_q  <= PH_T0;
        end else begin
          phase_q  <= PH_IDLE;
        end
      end else begin
        unique case (phase_q)
          PH_T0: begin
            LCD_EN  <= 1'b1;
            cnt_q   <= '0;
            phase_q <= PH_EN;
          end
          PH_EN: begin
            if (cnt_q == EN_LAST) begin
              LCD_EN  <= 1'b0;
              cnt_q   <= '0;
              phase_q <= PH_WAIT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PH_WAIT: cnt_q <= cnt_q + 1'b1;
          PH_IDLE: cnt_q <= cnt_q + 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl: three builds (4x2, 4x1, 3x2) with short timings,
// each released from reset in turn and checked cycle by cycle against hand-made vectors.
module tb_lcd_text_ctrl;

  localparam int EN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0, rst1, rst2;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  logic [7:0] lcd_data [3];
  logic       lcd_rw   [3];
  logic       lcd_en   [3];
  logic       lcd_rs   [3];
  logic       ready    [3];
  logic       frame    [3];

  int          sel;
  int          tests;
  int          fails;
  int unsigned cyc_no;

  logic [2:0]  pw_addr [8];
  logic [7:0]  pw_data [8];
  int          pw_n;

  lcd_text_ctrl #(.LCD_COLS(4), .LCD_ROWS(2), .PWRUP_CYC(20), .EN_CYC(2), .CMD_CYC(5),
                  .CLR_CYC(10), .REFRESH_CYC(8)) dut0 (
    .iCLK(clk), .iRST(rst0), .iWR_EN(wr_en), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
    .oREADY(ready[0]), .oFRAME(frame[0]), .LCD_DATA(lcd_data[0]), .LCD_RW(lcd_rw[0]),
    .LCD_EN(lcd_en[0]), .LCD_RS(lcd_rs[0]));

  lcd_text_ctrl #(.LCD_COLS(4), .LCD_ROWS(1), .PWRUP_CYC(20), .EN_CYC(2), .CMD_CYC(5),
                  .CLR_CYC(10), .REFRESH_CYC(8)) dut1 (
    .iCLK(clk), .iRST(rst1), .iWR_EN(wr_en), .iWR_ADDR(wr_addr[1:0]), .iWR_DATA(wr_data),
    .oREADY(ready[1]), .oFRAME(frame[1]), .LCD_DATA(lcd_data[1]), .LCD_RW(lcd_rw[1]),
    .LCD_EN(lcd_en[1]), .LCD_RS(lcd_rs[1]));

  lcd_text_ctrl #(.LCD_COLS(3), .LCD_ROWS(2), .PWRUP_CYC(20), .EN_CYC(2), .CMD_CYC(5),
                  .CLR_CYC(10), .REFRESH_CYC(8)) dut2 (
    .iCLK(clk), .iRST(rst2), .iWR_EN(wr_en), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
    .oREADY(ready[2]), .oFRAME(frame[2]), .LCD_DATA(lcd_data[2]), .LCD_RW(lcd_rw[2]),
    .LCD_EN(lcd_en[2]), .LCD_RS(lcd_rs[2]));

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc_no++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Walks one transfer from its T0 to the next T0, optionally driving a host write
  // on the cycle at offset wr_at (0 = T0).
  task automatic xfer(input string tag, input logic [7:0] d, input logic rs, input int wt,
                      input int wr_at = -1, input logic [2:0] wa = 3'd0,
                      input logic [7:0] wd = 8'h00);
    for (int k = 0; k <= EN + wt; k++) begin
      if (k == wr_at) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end else begin
        wr_en = 1'b0;
      end
      chk({tag, ".data"}, 32'(lcd_data[sel]), 32'(d));
      chk({tag, ".rs"},   32'(lcd_rs[sel]),   32'(rs));
      chk({tag, ".en"},   32'(lcd_en[sel]),   32'((k >= 1) && (k <= EN)));
      cyc(1);
    end
    wr_en = 1'b0;
  endtask

  // Called on the first cycle after the reset edge.
  task automatic pwrup();
    chk("rst.data",  32'(lcd_data[sel]), 32'h00);
    chk("rst.rs",    32'(lcd_rs[sel]),   32'h0);
    chk("rst.ready", 32'(ready[sel]),    32'h0);
    chk("rst.frame", 32'(frame[sel]),    32'h0);
    chk("rst.rw",    32'(lcd_rw[sel]),   32'h0);
    for (int i = 0; i < 20; i++) begin
      if (i < pw_n) begin
        wr_en = 1'b1; wr_addr = pw_addr[i]; wr_data = pw_data[i];
      end else begin
        wr_en = 1'b0;
      end
      chk("pwr.en",    32'(lcd_en[sel]), 32'h0);
      chk("pwr.ready", 32'(ready[sel]),  32'h0);
      cyc(1);
    end
    wr_en = 1'b0;
  endtask

  task automatic init_seq(input logic [7:0] fset);
    xfer("fset", fset,  1'b0, 5);
    xfer("disp", 8'h0C, 1'b0, 5);
    xfer("mode", 8'h06, 1'b0, 5);
    chk("clr.ready", 32'(ready[sel]), 32'h0);
    xfer("clr",  8'h01, 1'b0, 10);
    chk("init.ready", 32'(ready[sel]), 32'h1);
  endtask

  // Called on the oFRAME cycle; returns on the T0 of the next frame.
  task automatic gap();
    chk("frame.pulse", 32'(frame[sel]),  32'h1);
    chk("frame.en",    32'(lcd_en[sel]), 32'h0);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("gap.en",    32'(lcd_en[sel]), 32'h0);
      chk("gap.frame", 32'(frame[sel]),  32'h0);
    end
    cyc(1);
  endtask

  task automatic frame_chk(input int rows, input int cols, input logic [31:0] r0,
                           input logic [31:0] r1, input int unsigned len);
    int unsigned t0;
    logic [31:0] rr;
    t0 = cyc_no;
    for (int r = 0; r < rows; r++) begin
      rr = (r == 0) ? r0 : r1;
      xfer((r == 0) ? "addr0" : "addr1", (r == 0) ? 8'h80 : 8'hC0, 1'b0, 5);
      for (int c = 0; c < cols; c++) begin
        if (r == rows - 1 && c == cols - 1) chk("last.frame", 32'(frame[sel]), 32'h0);
        xfer($sformatf("r%0dc%0d", r, c), rr[31-8*c -: 8], 1'b1, 5);
      end
    end
    chk("frame.len", cyc_no - t0, len);
    gap();
  endtask

  initial begin
    int unsigned t0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sel = 0; tests = 0; fails = 0; cyc_no = 0; pw_n = 0;

    // Build 0: host loads "ABCDEFGH" during power-up wait
    cyc(3);
    rst0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pw_addr[i] = 3'(i);
      pw_data[i] = 8'(8'h41 + i);
    end
    pw_n = 8;
    pwrup();
    init_seq(8'h38);

    t0 = cyc_no;
    xfer("f1.addr0", 8'h80, 1'b0, 5);
    xfer("f1.r0c0", 8'h41, 1'b1, 5);
    xfer("f1.r0c1", 8'h42, 1'b1, 5);
    xfer("f1.r0c2", 8'h43, 1'b1, 5);
    xfer("f1.r0c3", 8'h44, 1'b1, 5);
    xfer("f1.addr1", 8'hC0, 1'b0, 5);
    xfer("f1.r1c0", 8'h45, 1'b1, 5, 1, 3'd5, 8'h5A);
    xfer("f1.r1c1", 8'h5A, 1'b1, 5, EN + 5, 3'd6, 8'h59);
    xfer("f1.r1c2", 8'h47, 1'b1, 5);
    chk("f1.last.frame", 32'(frame[0]), 32'h0);
    xfer("f1.r1c3", 8'h48, 1'b1, 5);
    chk("f1.len", cyc_no - t0, 32'd80);
    gap();

    xfer("f2.addr0", 8'h80, 1'b0, 5);
    xfer("f2.r0c0", 8'h41, 1'b1, 5);
    xfer("f2.r0c1", 8'h42, 1'b1, 5);
    xfer("f2.r0c2", 8'h43, 1'b1, 5);
    xfer("f2.r0c3", 8'h44, 1'b1, 5);
    xfer("f2.addr1", 8'hC0, 1'b0, 5);
    xfer("f2.r1c0", 8'h45, 1'b1, 5);
    xfer("f2.r1c1", 8'h5A, 1'b1, 5);
    chk("f2.r1c2.data", 32'(lcd_data[0]), 32'h59);
    chk("f2.r1c2.en",   32'(lcd_en[0]),   32'h0);
    cyc(1);
    chk("f2.r1c2.en_hi", 32'(lcd_en[0]), 32'h1);

    // Reset during EN high: EN must drop at once and everything replays blank
    rst0 = 1'b1;
    cyc(1);
    chk("rst.en_drop", 32'(lcd_en[0]), 32'h0);
    rst0 = 1'b0;
    pw_n = 0;
    pwrup();
    init_seq(8'h38);
    frame_chk(2, 4, {4{8'h20}}, {4{8'h20}}, 80);
    xfer("f4.addr0", 8'h80, 1'b0, 5);
    rst0 = 1'b1;

    // Build 1: single row
    sel = 1;
    rst1 = 1'b0;
    pwrup();
    init_seq(8'h30);
    frame_chk(1, 4, {4{8'h20}}, {4{8'h20}}, 40);
    xfer("b1.next.addr0", 8'h80, 1'b0, 5);
    rst1 = 1'b1;

    // Build 2: 6-char buffer, writes to indices 6 and 7 fall outside it
    sel = 2;
    rst2 = 1'b0;
    pw_addr[0] = 3'd6; pw_data[0] = 8'h51;
    pw_addr[1] = 3'd7; pw_data[1] = 8'h52;
    pw_addr[2] = 3'd2; pw_data[2] = 8'h53;
    pw_n = 3;
    pwrup();
    init_seq(8'h38);
    frame_chk(2, 3, {8'h20, 8'h20, 8'h53, 8'h00}, {8'h20, 8'h20, 8'h20, 8'h00}, 64);
    xfer("b2.next.addr0", 8'h80, 1'b0, 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
